// File: rtl/controle_multi_if.sv
// Control bus between the multicycle controller and the RV32I datapath.
// oIllegal exists only when CTRL_ILLEGAL_TRAP_EN is defined.
interface controle_multi_if;
  logic [6:0] iOp;
  logic       oIouD;
  logic       oEscreveIR;
  logic       MDRWrite;
  logic       oMemWrite;
  logic       oEscrevePC;
  logic       oEscrevePCCond;
  logic       oEscrevePCBack;
  logic       oOrigPC;
  logic [1:0] oOrigAULA;
  logic [1:0] oOrigBULA;
  logic [1:0] oALUOp;
  logic [1:0] oMem2Reg;
  logic       oEscreveReg;
  logic [3:0] oEstado;
`ifdef CTRL_ILLEGAL_TRAP_EN
  logic       oIllegal;
`endif

  // Controller side
  modport master (
    input  iOp,
    output oIouD, oEscreveIR, MDRWrite, oMemWrite, oEscrevePC, oEscrevePCCond,
           oEscrevePCBack, oOrigPC, oOrigAULA, oOrigBULA, oALUOp, oMem2Reg,
           oEscreveReg, oEstado
`ifdef CTRL_ILLEGAL_TRAP_EN
    , output oIllegal
`endif
  );

  // Datapath side
  modport slave (
    output iOp,
    input  oIouD, oEscreveIR, MDRWrite, oMemWrite, oEscrevePC, oEscrevePCCond,
           oEscrevePCBack, oOrigPC, oOrigAULA, oOrigBULA, oALUOp, oMem2Reg,
           oEscreveReg, oEstado
`ifdef CTRL_ILLEGAL_TRAP_EN
    , input oIllegal
`endif
  );
endinterface

// File: rtl/controle_multi.sv
// Main control FSM of the RV32I multicycle core; FETCH/MEMREAD stretched by MEM_WAIT cycles.
// Optional CTRL_ILLEGAL_TRAP_EN: illegal opcodes halt in state 15 with oIllegal set.
module controle_multi #(
  parameter int unsigned MEM_WAIT = 0
) (
  input  logic             clockCPU,
  input  logic             reset,
  controle_multi_if.master bus
);
  localparam int unsigned CNT_W = 4;
  localparam logic [CNT_W-1:0] WAIT_LAST = CNT_W'(MEM_WAIT);

  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;
  localparam logic [6:0] OP_R     = 7'b0110011;
  localparam logic [6:0] OP_I     = 7'b0010011;
  localparam logic [6:0] OP_BR    = 7'b1100011;
  localparam logic [6:0] OP_JAL   = 7'b1101111;
  localparam logic [6:0] OP_JALR  = 7'b1100111;
  localparam logic [6:0] OP_LUI   = 7'b0110111;

  typedef enum logic [3:0] {
    FETCH    = 4'd0,  DECODE = 4'd1,  MEMADR = 4'd2,  MEMREAD = 4'd3,
    MEMWB    = 4'd4,  MEMWRITE = 4'd5, EXEC_R = 4'd6, ALUWB   = 4'd7,
    BRANCH   = 4'd8,  JAL    = 4'd9,  JALR   = 4'd10, EXEC_I  = 4'd11,
    LUI      = 4'd12, SPARE13 = 4'd13, SPARE14 = 4'd14, HALT  = 4'd15
  } state_t;

  typedef struct packed {
    logic       iou_d;
    logic       escreve_ir;
    logic       mdr_write;
    logic       mem_write;
    logic       escreve_pc;
    logic       escreve_pc_cond;
    logic       escreve_pc_back;
    logic       orig_pc;
    logic [1:0] orig_a;
    logic [1:0] orig_b;
    logic [1:0] alu_op;
    logic [1:0] mem2reg;
    logic       escreve_reg;
  } ctl_t;

  state_t           state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic             started;
  ctl_t             ctl, ctl_nxt;

  // Moore output table; evaluated on the next state so the registered outputs track the state
  function automatic ctl_t moore_outputs(input state_t s, input logic [CNT_W-1:0] c);
    ctl_t o;
    logic last;
    o    = '0;
    last = (c == WAIT_LAST);
    case (s)
      FETCH: begin
        o.orig_b          = 2'b01;
        o.escreve_ir      = last;
        o.escreve_pc      = last;
        o.escreve_pc_back = last;
      end
      DECODE:   begin o.orig_a = 2'b10; o.orig_b = 2'b10; end
      MEMADR:   begin o.orig_a = 2'b01; o.orig_b = 2'b10; end
      MEMREAD:  begin o.iou_d = 1'b1; o.mdr_write = last; end
      MEMWB:    begin o.escreve_reg = 1'b1; o.mem2reg = 2'b01; end
      MEMWRITE: begin o.iou_d = 1'b1; o.mem_write = 1'b1; end
      EXEC_R:   begin o.orig_a = 2'b01; o.alu_op = 2'b10; end
      EXEC_I:   begin o.orig_a = 2'b01; o.orig_b = 2'b10; o.alu_op = 2'b10; end
      ALUWB:    o.escreve_reg = 1'b1;
      BRANCH: begin
        o.orig_a          = 2'b01;
        o.alu_op          = 2'b01;
        o.escreve_pc_cond = 1'b1;
        o.orig_pc         = 1'b1;
      end
      JAL: begin
        o.orig_a = 2'b10; o.orig_b = 2'b10;
        o.escreve_pc = 1'b1; o.escreve_reg = 1'b1; o.mem2reg = 2'b10;
      end
      JALR: begin
        o.orig_a = 2'b01; o.orig_b = 2'b10;
        o.escreve_pc = 1'b1; o.escreve_reg = 1'b1; o.mem2reg = 2'b10;
      end
      LUI:      begin o.escreve_reg = 1'b1; o.mem2reg = 2'b11; end
      default:  ;
    endcase
    return o;
  endfunction

  // Next state / wait counter; the first edge after reset only enters FETCH
  always_comb begin
    state_nxt = FETCH;
    cnt_nxt   = '0;
    if (started) begin
      case (state)
        FETCH, MEMREAD: begin
          if (cnt == WAIT_LAST) begin
            state_nxt = (state == FETCH) ? DECODE : MEMWB;
          end else begin
            state_nxt = state;
            cnt_nxt   = cnt + CNT_W'(1);
          end
        end
        DECODE: begin
          case (bus.iOp)
            OP_LOAD, OP_STORE: state_nxt = MEMADR;
            OP_R:              state_nxt = EXEC_R;
            OP_I:              state_nxt = EXEC_I;
            OP_BR:             state_nxt = BRANCH;
            OP_JAL:            state_nxt = JAL;
            OP_JALR:           state_nxt = JALR;
            OP_LUI:            state_nxt = LUI;
`ifdef CTRL_ILLEGAL_TRAP_EN
            default:           state_nxt = HALT;
`else
            default:           state_nxt = FETCH;
`endif
          endcase
        end
        MEMADR:        state_nxt = bus.iOp[5] ? MEMWRITE : MEMREAD;
        EXEC_R, EXEC_I: state_nxt = ALUWB;
`ifdef CTRL_ILLEGAL_TRAP_EN
        HALT:          state_nxt = HALT;
`endif
        default:       state_nxt = FETCH;
      endcase
    end
    ctl_nxt = moore_outputs(state_nxt, cnt_nxt);
  end

  always_ff @(posedge clockCPU or negedge reset) begin
    if (!reset) begin
      state   <= FETCH;
      cnt     <= '0;
      started <= 1'b0;
      ctl     <= '0;
    end else begin
      state   <= state_nxt;
      cnt     <= cnt_nxt;
      started <= 1'b1;
      ctl     <= ctl_nxt;
    end
  end

`ifdef CTRL_ILLEGAL_TRAP_EN
  logic illegal_q;

  always_ff @(posedge clockCPU or negedge reset) begin
    if (!reset) illegal_q <= 1'b0;
    else        illegal_q <= (state_nxt == HALT);
  end

  assign bus.oIllegal = illegal_q;
`endif

  assign bus.oEstado        = state;
  assign bus.oIouD          = ctl.iou_d;
  assign bus.oEscreveIR     = ctl.escreve_ir;
  assign bus.MDRWrite       = ctl.mdr_write;
  assign bus.oMemWrite      = ctl.mem_write;
  assign bus.oEscrevePC     = ctl.escreve_pc;
  assign bus.oEscrevePCCond = ctl.escreve_pc_cond;
  assign bus.oEscrevePCBack = ctl.escreve_pc_back;
  assign bus.oOrigPC        = ctl.orig_pc;
  assign bus.oOrigAULA      = ctl.orig_a;
  assign bus.oOrigBULA      = ctl.orig_b;
  assign bus.oALUOp         = ctl.alu_op;
  assign bus.oMem2Reg       = ctl.mem2reg;
  assign bus.oEscreveReg    = ctl.escreve_reg;
endmodule

// File: tb/tb_controle_multi.sv
// Bench for controle_multi: MEM_WAIT=0 and MEM_WAIT=2 instances, random opcode streams
// checked cycle by cycle against a per-instruction schedule model.
module tb_controle_multi;
  typedef logic [20:0] vec_t;

  localparam logic [6:0] OP_LD   = 7'b0000011;
  localparam logic [6:0] OP_ST   = 7'b0100011;
  localparam logic [6:0] OP_R    = 7'b0110011;
  localparam logic [6:0] OP_I    = 7'b0010011;
  localparam logic [6:0] OP_BR   = 7'b1100011;
  localparam logic [6:0] OP_JAL  = 7'b1101111;
  localparam logic [6:0] OP_JALR = 7'b1100111;
  localparam logic [6:0] OP_LUI  = 7'b0110111;
  localparam logic [6:0] LEGAL [8] = '{OP_LD, OP_ST, OP_R, OP_I, OP_BR, OP_JAL, OP_JALR, OP_LUI};
  localparam logic [6:0] DIRECTED [6] = '{OP_LD, OP_ST, OP_BR, OP_JAL, OP_R, OP_I};

  logic clockCPU;
  logic reset;
  int   errors = 0;
  int   checks = 0;

  controle_multi_if if0 ();
  controle_multi_if if2 ();

  controle_multi #(.MEM_WAIT(0)) dut0 (.clockCPU(clockCPU), .reset(reset), .bus(if0));
  controle_multi #(.MEM_WAIT(2)) dut2 (.clockCPU(clockCPU), .reset(reset), .bus(if2));

  vec_t obs0, obs2;
  assign obs0 = {if0.oEstado, if0.oIouD, if0.oEscreveIR, if0.MDRWrite, if0.oMemWrite,
                 if0.oEscrevePC, if0.oEscrevePCCond, if0.oEscrevePCBack, if0.oOrigPC,
                 if0.oOrigAULA, if0.oOrigBULA, if0.oALUOp, if0.oMem2Reg, if0.oEscreveReg};
  assign obs2 = {if2.oEstado, if2.oIouD, if2.oEscreveIR, if2.MDRWrite, if2.oMemWrite,
                 if2.oEscrevePC, if2.oEscrevePCCond, if2.oEscrevePCBack, if2.oOrigPC,
                 if2.oOrigAULA, if2.oOrigBULA, if2.oALUOp, if2.oMem2Reg, if2.oEscreveReg};

  initial clockCPU = 1'b0;
  always #5 clockCPU = ~clockCPU;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Expected output bundle: state, then enables, then selects
  function automatic vec_t mk(input int st, input int iou, input int ir, input int mdr,
                              input int mw, input int pc, input int pcc, input int pcb,
                              input int opc, input int a, input int b, input int alu,
                              input int m2r, input int rg);
    return {4'(st), 1'(iou), 1'(ir), 1'(mdr), 1'(mw), 1'(pc), 1'(pcc), 1'(pcb), 1'(opc),
            2'(a), 2'(b), 2'(alu), 2'(m2r), 1'(rg)};
  endfunction

  function automatic bit is_legal(input logic [6:0] op);
    for (int i = 0; i < 8; i++) if (LEGAL[i] == op) return 1'b1;
    return 1'b0;
  endfunction

  // Instruction length in cycles from the published latency rules
  function automatic int seq_len(input logic [6:0] op, input int w);
    case (op)
      OP_LD:                          return 5 + 2 * w;
      OP_ST, OP_R, OP_I:              return 4 + w;
      OP_BR, OP_JAL, OP_JALR, OP_LUI: return 3 + w;
      default:                        return 2 + w;
    endcase
  endfunction

  // Expected bundle k cycles into an instruction with opcode op and wait count w
  function automatic vec_t exp_at(input logic [6:0] op, input int w, input int k);
    int j;
    j = k - (w + 2);
    if (k < w)  return mk(0, 0,0,0,0, 0,0,0,0, 0,1,0,0, 0);
    if (k == w) return mk(0, 0,1,0,0, 1,0,1,0, 0,1,0,0, 0);
    if (j < 0)  return mk(1, 0,0,0,0, 0,0,0,0, 2,2,0,0, 0);
    case (op)
      OP_LD: begin
        if (j == 0)     return mk(2, 0,0,0,0, 0,0,0,0, 1,2,0,0, 0);
        if (j <= w + 1) return mk(3, 1,0,(j == w + 1) ? 1 : 0,0, 0,0,0,0, 0,0,0,0, 0);
        return mk(4, 0,0,0,0, 0,0,0,0, 0,0,0,1, 1);
      end
      OP_ST:   return (j == 0) ? mk(2, 0,0,0,0, 0,0,0,0, 1,2,0,0, 0)
                               : mk(5, 1,0,0,1, 0,0,0,0, 0,0,0,0, 0);
      OP_R:    return (j == 0) ? mk(6, 0,0,0,0, 0,0,0,0, 1,0,2,0, 0)
                               : mk(7, 0,0,0,0, 0,0,0,0, 0,0,0,0, 1);
      OP_I:    return (j == 0) ? mk(11, 0,0,0,0, 0,0,0,0, 1,2,2,0, 0)
                               : mk(7, 0,0,0,0, 0,0,0,0, 0,0,0,0, 1);
      OP_BR:   return mk(8,  0,0,0,0, 0,1,0,1, 1,0,1,0, 0);
      OP_JAL:  return mk(9,  0,0,0,0, 1,0,0,0, 2,2,0,2, 1);
      OP_JALR: return mk(10, 0,0,0,0, 1,0,0,0, 1,2,0,2, 1);
      OP_LUI:  return mk(12, 0,0,0,0, 0,0,0,0, 0,0,0,3, 1);
      default: return mk(15, 0,0,0,0, 0,0,0,0, 0,0,0,0, 0);
    endcase
  endfunction

  function automatic logic [6:0] pick_op();
    int idx;
    logic [6:0] op;
`ifdef CTRL_ILLEGAL_TRAP_EN
    idx = $urandom_range(0, 7);
`else
    idx = $urandom_range(0, 8);
`endif
    if (idx < 8) return LEGAL[idx];
    for (int t = 0; t < 16; t++) begin
      op = 7'($urandom);
      if (!is_legal(op)) return op;
    end
    return 7'b1111111;
  endfunction

  // Called at the negedge of the first FETCH cycle; returns at the next instruction's first cycle
  task automatic run_inst(input bit sel, input logic [6:0] op);
    int w;
    int n;
    w = sel ? 2 : 0;
    if (sel) if2.iOp = op; else if0.iOp = op;
    n = seq_len(op, w);
    for (int k = 0; k < n; k++) begin
      check($sformatf("w%0d_op%02h_c%0d", w, op, k),
            sel ? 32'(obs2) : 32'(obs0), 32'(exp_at(op, w, k)));
      @(negedge clockCPU);
    end
  endtask

  task automatic stream(input bit sel);
    for (int i = 0; i < 6; i++) run_inst(sel, DIRECTED[i]);
`ifndef CTRL_ILLEGAL_TRAP_EN
    run_inst(sel, 7'b1111111);
`endif
    for (int i = 0; i < 40; i++) run_inst(sel, pick_op());
  endtask

  task automatic check_idle(input string tag);
    check({tag, "_w0"}, 32'(obs0), 32'd0);
    check({tag, "_w2"}, 32'(obs2), 32'd0);
`ifdef CTRL_ILLEGAL_TRAP_EN
    check({tag, "_ill"}, 32'(if0.oIllegal), 32'd0);
`endif
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    bit found;
    reset   = 1'b0;
    if0.iOp = 7'd0;
    if2.iOp = 7'd0;
    repeat (3) @(negedge clockCPU);
    check_idle("reset");
    reset = 1'b1;
    #1 check_idle("release");
    @(negedge clockCPU);

    fork
      stream(1'b0);
      stream(1'b1);
    join

`ifdef CTRL_ILLEGAL_TRAP_EN
    if0.iOp = 7'b1111111;
    for (int k = 0; k < 2; k++) begin
      check($sformatf("ill_pre_c%0d", k), 32'(obs0), 32'(exp_at(7'b1111111, 0, k)));
      @(negedge clockCPU);
    end
    repeat (10) begin
      check("halt_state", 32'(obs0), 32'(mk(15, 0,0,0,0, 0,0,0,0, 0,0,0,0, 0)));
      check("halt_flag", 32'(if0.oIllegal), 32'd1);
      @(negedge clockCPU);
    end
`endif

    // Abort a load in the middle of MEMREAD on the slow-memory instance
    if2.iOp = OP_LD;
    found   = 1'b0;
    for (int t = 0; t < 20 && !found; t++) begin
      if (if2.oEstado == 4'd3) found = 1'b1;
      else @(negedge clockCPU);
    end
    check("reach_memread", 32'(found), 32'd1);
    #2 reset = 1'b0;
    #1 check_idle("async_rst");
    @(posedge clockCPU);
    #1 check_idle("rst_hold");
    @(negedge clockCPU);
    reset = 1'b1;
    #1 check_idle("rst_rel2");
    @(negedge clockCPU);
    fork
      run_inst(1'b0, OP_LD);
      run_inst(1'b1, OP_LD);
    join

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
